// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that grants one JK command per cycle onto a shared
// bank of JK flip-flops, with a one-cycle issue stage ahead of the bank.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_jk,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic [IDW-1:0]       gnt_id,
  output logic                 issue,
  output logic                 err,
  output logic [NBITS-1:0]     jk_j,
  output logic [NBITS-1:0]     jk_k,
  output logic [NBITS-1:0]     q
);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   nxt_ptr;
  logic             win_vld;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  win_onehot;
  logic [1:0]       win_jk;
  logic [AW-1:0]    win_addr;
  logic             addr_ok;
  logic [NBITS-1:0] dec_j;
  logic [NBITS-1:0] dec_k;

  // The requester granted this cycle is masked so its next command waits a cycle.
  assign eligible = req & ~gnt;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch can be inferred on any path.
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    // Scan from the farthest offset down so the nearest eligible index wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDW'((int'(rr_ptr) + off) % NREQ);
      if (eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_jk     = 2'b00;
    win_addr   = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_jk        = req_jk[2*i +: 2];
        win_addr      = req_addr[AW*i +: AW];
        win_onehot[i] = win_vld;
      end
    end
  end

  assign nxt_ptr = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign addr_ok = int'(win_addr) < NBITS;

  always_comb begin
    dec_j = '0;
    dec_k = '0;
    for (int b = 0; b < NBITS; b++) begin
      dec_j[b] = (win_addr == AW'(b)) & win_jk[1];
      dec_k[b] = (win_addr == AW'(b)) & win_jk[0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<='; every register here,
    // including the bank, is reset so a pre-reset grant leaves no trace.
    if (rst) begin
      rr_ptr <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      issue  <= 1'b0;
      err    <= 1'b0;
      jk_j   <= '0;
      jk_k   <= '0;
      q      <= '0;
    end else begin
      if (win_vld) begin
        rr_ptr <= nxt_ptr;
        gnt    <= win_onehot;
        gnt_id <= win_idx;
        issue  <= 1'b1;
        err    <= ~addr_ok;
        jk_j   <= dec_j;
        jk_k   <= dec_k;
      end else begin
        gnt    <= '0;
        issue  <= 1'b0;
        err    <= 1'b0;
        jk_j   <= '0;
        jk_k   <= '0;
      end
      // Idle bits see J=K=0 and hold, so the whole bank updates uniformly.
      if (clr) q <= '0;
      else     q <= (jk_j & ~q) | (~jk_k & q);
    end
  end

endmodule
